domain_sequencer: RTL and testbench

Parametrised power-up/power-down sequencer for one clock domain, instantiated once per domain beside that domain's clock-lock logic. It synchronises a domain enable request, holds the domain in `sync_rst`, and raises `clk_en` after a programmable rest period. It then issues a single-cycle `init` and reports `ready`. Unlike a fixed shift-register sequencer, it also performs an orderly shutdown: it requests a drain, waits for acknowledge or timeout, then gates the clock and re-asserts reset.

---
 rtl/domain_seq_pkg.sv | 33 +++
 rtl/domain_sequencer_if.sv | 39 +++
 rtl/bit_synchronizer.sv | 30 +++
 rtl/domain_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_domain_sequencer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/domain_seq_pkg.sv
// Shared types and helpers for the per-domain power sequencer.
// Contents: the sequencer state encoding and the counter width helper.
// No ports; imported by domain_sequencer.
package domain_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_REST,
        ST_INIT_WAIT,
        ST_INIT,
        ST_RUN,
        ST_DRAIN,
        ST_HALT
    } domain_seq_state_t;

    // Width of the shared down-counter: wide enough for the largest timed
    // state length. Counters are loaded with length-1, so this leaves margin.
    function automatic int seq_cnt_width(input int rst_cycles,
                                         input int rest_cycles,
                                         input int init_delay,
                                         input int drain_timeout,
                                         input int halt_cycles);
        int m;
        m = rst_cycles;
        if (rest_cycles   > m) m = rest_cycles;
        if (init_delay    > m) m = init_delay;
        if (drain_timeout > m) m = drain_timeout;
        if (halt_cycles   > m) m = halt_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/domain_sequencer_if.sv
// Control bundle between a domain sequencer and the clock domain it manages.
// Requests in: domain_enable, drain_ack (both asynchronous levels).
// Controls out: clk_en, sync_rst, init, drain_req, ready, drain_timeout.
interface domain_sequencer_if;

    logic domain_enable;
    logic drain_ack;
    logic clk_en;
    logic sync_rst;
    logic init;
    logic drain_req;
    logic ready;
    logic drain_timeout;

    // Sequencer side.
    modport master (
        input  domain_enable,
        input  drain_ack,
        output clk_en,
        output sync_rst,
        output init,
        output drain_req,
        output ready,
        output drain_timeout
    );

    // Managed domain / requester side.
    modport slave (
        output domain_enable,
        output drain_ack,
        input  clk_en,
        input  sync_rst,
        input  init,
        input  drain_req,
        input  ready,
        input  drain_timeout
    );

endinterface

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous level into clk.
// Ports: clk, async_rst (async, active-high, clears chain to 0), d in, q out.
// Latency is STAGES edges from d to q.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic async_rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/domain_sequencer.sv
// Power-up / orderly power-down sequencer for one clock domain.
// Ports: clk, async_rst (async, active-high); bus carries the enable/ack
// requests in and clk_en/sync_rst/init/drain_req/ready/drain_timeout out.
module domain_sequencer
    import domain_seq_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int RST_CYCLES    = 4,
    parameter int REST_CYCLES   = 2,
    parameter int INIT_DELAY    = 2,
    parameter int DRAIN_TIMEOUT = 16,
    parameter int HALT_CYCLES   = 2
) (
    input  logic                clk,
    input  logic                async_rst,
    domain_sequencer_if.master  bus
);

    localparam int CW = seq_cnt_width(RST_CYCLES, REST_CYCLES, INIT_DELAY,
                                      DRAIN_TIMEOUT, HALT_CYCLES);
    typedef logic [CW-1:0] cnt_t;

    // Counter is loaded with length-1 on entry and the state exits when it
    // reads 0, so each timed state lasts exactly its parameter in cycles.
    localparam cnt_t RST_LOAD   = cnt_t'(RST_CYCLES - 1);
    localparam cnt_t REST_LOAD  = cnt_t'(REST_CYCLES - 1);
    localparam cnt_t INIT_LOAD  = cnt_t'(INIT_DELAY - 1);
    localparam cnt_t DRAIN_LOAD = cnt_t'(DRAIN_TIMEOUT - 1);
    localparam cnt_t HALT_LOAD  = cnt_t'(HALT_CYCLES - 1);
    localparam cnt_t CNT_ONE    = cnt_t'(1);

    logic en;
    logic ack;

    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_en (
        .clk       (clk),
        .async_rst (async_rst),
        .d         (bus.domain_enable),
        .q         (en)
    );

    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_ack (
        .clk       (clk),
        .async_rst (async_rst),
        .d         (bus.drain_ack),
        .q         (ack)
    );

    domain_seq_state_t state_q, state_d;
    cnt_t              cnt_q, cnt_d;
    logic              clk_en_q, clk_en_d;
    logic              sync_rst_q, sync_rst_d;
    logic              init_q, init_d;
    logic              drain_req_q, drain_req_d;
    logic              ready_q, ready_d;
    logic              drain_timeout_q, drain_timeout_d;
    logic              timeout_hit;
    logic              cnt_zero;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timeout_hit = 1'b0;
        cnt_zero    = (cnt_q == '0);

        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_RESET;
                    cnt_d   = RST_LOAD;
                end
            end
            // Clock has not been enabled yet, so an abort needs no drain.
            ST_RESET: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (cnt_zero) begin
                    state_d = ST_REST;
                    cnt_d   = REST_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_REST: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (cnt_zero) begin
                    state_d = ST_INIT_WAIT;
                    cnt_d   = INIT_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            // Clock is running from here on: shutdown must go via DRAIN.
            ST_INIT_WAIT: begin
                if (!en) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end else if (cnt_zero) begin
                    state_d = ST_INIT;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_INIT: begin
                if (!en) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end
            end
            // ack takes priority over a coincident expiry, so the sticky
            // timeout flag only reports drains that truly never quiesced.
            ST_DRAIN: begin
                if (ack) begin
                    state_d = ST_HALT;
                    cnt_d   = HALT_LOAD;
                end else if (cnt_zero) begin
                    state_d     = ST_HALT;
                    cnt_d       = HALT_LOAD;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HALT: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs decode the next state so they change on the same edge.
        clk_en_d    = (state_d == ST_INIT_WAIT) || (state_d == ST_INIT) ||
                      (state_d == ST_RUN)       || (state_d == ST_DRAIN);
        sync_rst_d  = (state_d == ST_IDLE) || (state_d == ST_RESET);
        init_d      = (state_d == ST_INIT);
        ready_d     = (state_d == ST_RUN);
        drain_req_d = (state_d == ST_DRAIN);

        drain_timeout_d = drain_timeout_q;
        if (timeout_hit) begin
            drain_timeout_d = 1'b1;
        end
        if (state_d == ST_RESET) begin
            drain_timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            clk_en_q        <= 1'b0;
            sync_rst_q      <= 1'b1;
            init_q          <= 1'b0;
            drain_req_q     <= 1'b0;
            ready_q         <= 1'b0;
            drain_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            clk_en_q        <= clk_en_d;
            sync_rst_q      <= sync_rst_d;
            init_q          <= init_d;
            drain_req_q     <= drain_req_d;
            ready_q         <= ready_d;
            drain_timeout_q <= drain_timeout_d;
        end
    end

    assign bus.clk_en        = clk_en_q;
    assign bus.sync_rst      = sync_rst_q;
    assign bus.init          = init_q;
    assign bus.drain_req     = drain_req_q;
    assign bus.ready         = ready_q;
    assign bus.drain_timeout = drain_timeout_q;

endmodule

// File: tb/tb_domain_sequencer.sv
// Bench for domain_sequencer with default parameters.
// Output vector order: {clk_en, sync_rst, init, drain_req, ready, drain_timeout}.
// Each expected change of that vector is queued with its edge number.
module tb_domain_sequencer;

    logic clk = 1'b0;
    logic async_rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   mon_on = 1'b0;

    domain_sequencer_if bus ();

    domain_sequencer u_dut (
        .clk       (clk),
        .async_rst (async_rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    localparam logic [5:0] V_IDLE    = 6'b010000;
    localparam logic [5:0] V_ZERO    = 6'b000000;
    localparam logic [5:0] V_CLK     = 6'b100000;
    localparam logic [5:0] V_INIT    = 6'b101000;
    localparam logic [5:0] V_RUN     = 6'b100010;
    localparam logic [5:0] V_DRAIN   = 6'b100100;
    localparam logic [5:0] V_HALT_TO = 6'b000001;
    localparam logic [5:0] V_IDLE_TO = 6'b010001;

    typedef struct {
        int         edge_n;
        logic [5:0] val;
    } ev_t;

    ev_t        evq[$];
    logic [5:0] out_vec;
    logic [5:0] prev_vec = V_IDLE;

    assign out_vec = {bus.clk_en, bus.sync_rst, bus.init,
                      bus.drain_req, bus.ready, bus.drain_timeout};

    // Monitor: every change of the output vector must match the next
    // queued expectation, both in value and in the edge it appeared at.
    always @(negedge clk) begin
        if (mon_on && (out_vec !== prev_vec)) begin
            total++;
            if (evq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_change: edge %0d vec %b (none queued)", cyc, out_vec);
            end else begin
                ev_t e;
                e = evq.pop_front();
                if ((e.edge_n != cyc) || (e.val !== out_vec)) begin
                    bad++;
                    $display("FAIL event: got edge %0d vec %b, want edge %0d vec %b",
                             cyc, out_vec, e.edge_n, e.val);
                end
            end
            prev_vec = out_vec;
        end
    end

    task automatic push(input int e, input logic [5:0] v);
        ev_t x;
        x.edge_n = e;
        x.val    = v;
        evq.push_back(x);
    endtask

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    // Called at a negedge: returns at the negedge just before edge e.
    task automatic at_edge(input int e);
        while (cyc < e - 1) @(negedge clk);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && evq.size() != 0; i++) @(negedge clk);
        total++;
        if (evq.size() != 0) begin
            bad++;
            $display("FAIL drain_wait: %0d events outstanding, next due edge %0d",
                     evq.size(), evq[0].edge_n);
            evq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // b = first edge at which domain_enable is high.
    task automatic bringup_push(input int b, input bit had_to);
        if (had_to) push(b + 2, V_IDLE);
        push(b + 6,  V_ZERO);
        push(b + 8,  V_CLK);
        push(b + 10, V_INIT);
        push(b + 11, V_RUN);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int d;
        int k;
        int m;

        bus.domain_enable = 1'b0;
        bus.drain_ack     = 1'b0;
        #1 async_rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_vec", out_vec, V_IDLE);
        #2 async_rst = 1'b0;
        @(negedge clk);
        check("post_reset_vec", out_vec, V_IDLE);
        mon_on = 1'b1;

        // Abort while in RESET: nothing may change.
        b = cyc + 1;
        bus.domain_enable = 1'b1;
        at_edge(b + 3);
        bus.domain_enable = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_reset_idle", out_vec, V_IDLE);

        // Normal bring-up.
        b = cyc + 1;
        bringup_push(b, 1'b0);
        bus.domain_enable = 1'b1;
        wait_drain();

        // Clean shutdown, ack seen synchronised at d+5.
        d = cyc + 1;
        bus.domain_enable = 1'b0;
        push(d + 2, V_DRAIN);
        push(d + 5, V_ZERO);
        push(d + 7, V_IDLE);
        at_edge(d + 3);
        bus.drain_ack = 1'b1;
        wait_drain();
        bus.drain_ack = 1'b0;
        repeat (3) @(negedge clk);

        // Bring-up then drain timeout: drain_req high exactly 16 cycles.
        b = cyc + 1;
        bringup_push(b, 1'b0);
        bus.domain_enable = 1'b1;
        wait_drain();
        d = cyc + 1;
        bus.domain_enable = 1'b0;
        push(d + 2,  V_DRAIN);
        push(d + 18, V_HALT_TO);
        push(d + 20, V_IDLE_TO);
        wait_drain();
        check("timeout_sticky", {5'b0, bus.drain_timeout}, 6'b000001);

        // Re-enable: timeout flag clears on RESET entry.
        b = cyc + 1;
        bringup_push(b, 1'b1);
        bus.domain_enable = 1'b1;
        wait_drain();

        // Shutdown with enable re-raised during HALT: shutdown completes,
        // IDLE at d+7, RESET at d+8 (same relative timing as a fresh start).
        d = cyc + 1;
        bus.domain_enable = 1'b0;
        push(d + 2, V_DRAIN);
        push(d + 5, V_ZERO);
        push(d + 7, V_IDLE);
        bringup_push(d + 6, 1'b0);
        at_edge(d + 3);
        bus.drain_ack = 1'b1;
        at_edge(d + 5);
        bus.domain_enable = 1'b1;
        wait_drain();

        // Shutdown with ack already high: one-cycle DRAIN.
        d = cyc + 1;
        bus.domain_enable = 1'b0;
        push(d + 2, V_DRAIN);
        push(d + 3, V_ZERO);
        push(d + 5, V_IDLE);
        wait_drain();

        // Abort in INIT_WAIT: goes to DRAIN, init never pulses.
        b = cyc + 1;
        bus.domain_enable = 1'b1;
        push(b + 6,  V_ZERO);
        push(b + 8,  V_CLK);
        push(b + 9,  V_DRAIN);
        push(b + 10, V_ZERO);
        push(b + 12, V_IDLE);
        at_edge(b + 7);
        bus.domain_enable = 1'b0;
        wait_drain();
        bus.drain_ack = 1'b0;
        repeat (3) @(negedge clk);

        // async_rst pulse in RUN, then bring-up restarts after release.
        b = cyc + 1;
        bringup_push(b, 1'b0);
        bus.domain_enable = 1'b1;
        wait_drain();
        k = cyc;
        push(k + 1, V_IDLE);
        #2 async_rst = 1'b1;
        #1;
        check("arst_clk_en",   {5'b0, bus.clk_en},   6'b000000);
        check("arst_sync_rst", {5'b0, bus.sync_rst}, 6'b000001);
        check("arst_ready",    {5'b0, bus.ready},    6'b000000);
        repeat (3) @(negedge clk);
        m = cyc;
        bringup_push(m + 1, 1'b0);
        #2 async_rst = 1'b0;
        @(negedge clk);
        wait_drain();
        check("final_run", out_vec, V_RUN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
